ibex_wb_queue: RTL and testbench

//  Multi-entry in-order writeback stage between ID/EX and the register file.
//  - Holds up to Depth retiring instructions, so several loads/stores can be outstanding at once.
//  - Retires at most one entry per cycle, in program order.
//  - Resolves ID read hazards by youngest-match forwarding, or by stall when the youngest match is a load.
//  - Depth=1 is cycle-equivalent to the single-entry writeback stage.

---
 rtl/ibex_pkg.sv | 21 ++
 rtl/ibex_wb_fwd_match.sv | 27 ++
 rtl/ibex_wb_queue.sv | 191 +++++++++++++++++++
 tb/tb_ibex_wb_queue.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ibex_pkg.sv
// Shared types for the writeback queue: retiring-instruction class and the
// per-entry payload held while an instruction waits to write the register file.
package ibex_pkg;

  typedef enum logic [1:0] {
    WB_INSTR_LOAD  = 2'b00,
    WB_INSTR_STORE = 2'b01,
    WB_INSTR_OTHER = 2'b10
  } wb_instr_type_e;

  typedef struct packed {
    logic           we;
    logic [4:0]     waddr;
    logic [31:0]    wdata;
    wb_instr_type_e instr_type;
    logic [31:0]    pc;
    logic           compressed;
    logic           count;
  } wb_entry_t;

endpackage

// File: rtl/ibex_wb_fwd_match.sv
// Youngest-match selector for one ID read port. Inputs are in age order
// (bit 0 oldest), so the last matching entry in the scan is the youngest.
module ibex_wb_fwd_match #(
  parameter int unsigned Depth = 2
) (
  input  logic [Depth-1:0]       match,
  input  logic [Depth-1:0]       is_load,
  input  logic [Depth-1:0][31:0] wdata,
  output logic                   valid,
  output logic [31:0]            data,
  output logic                   stall
);

  always_comb begin
    valid = 1'b0;
    data  = '0;
    stall = 1'b0;
    for (int k = 0; k < Depth; k++) begin
      if (match[k]) begin
        valid = ~is_load[k];
        stall = is_load[k];
        data  = is_load[k] ? 32'h0 : wdata[k];
      end
    end
  end

endmodule

// File: rtl/ibex_wb_queue.sv
// Multi-entry in-order writeback queue between ID/EX and the register file:
// circular buffer, one retire per cycle, youngest-match forwarding/stall.
module ibex_wb_queue
  import ibex_pkg::*;
#(
  parameter int unsigned  Depth    = 2,
  parameter bit           ResetAll = 1'b0,
  localparam int unsigned CntW     = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            en_wb_i,
  input  logic [1:0]      instr_type_wb_i,
  input  logic [31:0]     pc_id_i,
  input  logic            instr_is_compressed_id_i,
  input  logic            instr_perf_count_id_i,
  input  logic [4:0]      rf_waddr_id_i,
  input  logic [31:0]     rf_wdata_id_i,
  input  logic            rf_we_id_i,
  input  logic [31:0]     rf_wdata_lsu_i,
  input  logic            rf_we_lsu_i,
  input  logic            lsu_resp_valid_i,
  input  logic            lsu_resp_err_i,
  input  logic [4:0]      rf_raddr_a_i,
  input  logic [4:0]      rf_raddr_b_i,
  output logic            ready_wb_o,
  output logic [4:0]      rf_waddr_wb_o,
  output logic [31:0]     rf_wdata_wb_o,
  output logic            rf_we_wb_o,
  output logic            outstanding_load_wb_o,
  output logic            outstanding_store_wb_o,
  output logic [31:0]     pc_wb_o,
  output logic            instr_done_wb_o,
  output logic            perf_instr_ret_wb_o,
  output logic            perf_instr_ret_compressed_wb_o,
  output logic [CntW-1:0] perf_instr_ret_spec_cnt_o,
  output logic [CntW-1:0] perf_instr_ret_c_spec_cnt_o,
  output logic            fwd_a_valid_o,
  output logic [31:0]     fwd_a_data_o,
  output logic            fwd_a_stall_o,
  output logic            fwd_b_valid_o,
  output logic [31:0]     fwd_b_data_o,
  output logic            fwd_b_stall_o,
  output logic [CntW-1:0] occupancy_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  wb_entry_t        entry_reg [Depth];
  logic [Depth-1:0] valid_reg;
  logic [PtrW-1:0]  head_ptr_reg, tail_ptr_reg;
  logic [CntW-1:0]  count_reg;

  wb_entry_t head, in_entry;
  logic      head_valid, head_done, full, enq, id_we;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == PtrW'(Depth - 1)) return '0;
    return p + PtrW'(1);
  endfunction

  assign head       = entry_reg[head_ptr_reg];
  assign head_valid = valid_reg[head_ptr_reg];
  assign head_done  = head_valid & ((head.instr_type == WB_INSTR_OTHER) | lsu_resp_valid_i);
  assign full       = (count_reg == CntW'(Depth));
  assign ready_wb_o = ~full | head_done;
  assign enq        = en_wb_i & ready_wb_o;

  assign in_entry = '{
    we:         rf_we_id_i,
    waddr:      rf_waddr_id_i,
    wdata:      rf_wdata_id_i,
    instr_type: wb_instr_type_e'(instr_type_wb_i),
    pc:         pc_id_i,
    compressed: instr_is_compressed_id_i,
    count:      instr_perf_count_id_i
  };

  // When full, head and tail coincide: the retire clear is overridden by the enqueue set.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_reg    <= '0;
      head_ptr_reg <= '0;
      tail_ptr_reg <= '0;
      count_reg    <= '0;
    end else begin
      if (head_done) begin
        valid_reg[head_ptr_reg] <= 1'b0;
        head_ptr_reg            <= ptr_inc(head_ptr_reg);
      end
      if (enq) begin
        valid_reg[tail_ptr_reg] <= 1'b1;
        tail_ptr_reg            <= ptr_inc(tail_ptr_reg);
      end
      count_reg <= count_reg + CntW'(enq) - CntW'(head_done);
    end
  end

  if (ResetAll) begin : g_payload_rst
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int k = 0; k < Depth; k++) entry_reg[k] <= '0;
      end else if (enq) begin
        entry_reg[tail_ptr_reg] <= in_entry;
      end
    end
  end else begin : g_payload
    always_ff @(posedge clk_i) begin
      if (enq) entry_reg[tail_ptr_reg] <= in_entry;
    end
  end

  // Register file write: ID result for a retiring OTHER, else load data from the LSU.
  assign id_we           = head_valid & (head.instr_type == WB_INSTR_OTHER) & head.we;
  assign rf_we_wb_o      = id_we | rf_we_lsu_i;
  assign rf_waddr_wb_o   = head_valid ? head.waddr : 5'd0;
  assign rf_wdata_wb_o   = ({32{id_we}} & head.wdata) | ({32{rf_we_lsu_i}} & rf_wdata_lsu_i);
  assign pc_wb_o         = head_valid ? head.pc : 32'h0;
  assign instr_done_wb_o = head_done;
  assign occupancy_o     = count_reg;

  assign perf_instr_ret_wb_o            = head_done & head.count &
                                          ~(lsu_resp_valid_i & lsu_resp_err_i);
  assign perf_instr_ret_compressed_wb_o = perf_instr_ret_wb_o & head.compressed;

  logic [Depth-1:0] is_load_slot, is_store_slot, cnt_slot, cnt_c_slot;

  for (genvar gi = 0; gi < Depth; gi++) begin : g_slot
    assign is_load_slot[gi]  = valid_reg[gi] & (entry_reg[gi].instr_type == WB_INSTR_LOAD);
    assign is_store_slot[gi] = valid_reg[gi] & (entry_reg[gi].instr_type == WB_INSTR_STORE);
    assign cnt_slot[gi]      = valid_reg[gi] & entry_reg[gi].count;
    assign cnt_c_slot[gi]    = valid_reg[gi] & entry_reg[gi].count & entry_reg[gi].compressed;
  end

  assign outstanding_load_wb_o  = |is_load_slot;
  assign outstanding_store_wb_o = |is_store_slot;

  always_comb begin
    perf_instr_ret_spec_cnt_o   = '0;
    perf_instr_ret_c_spec_cnt_o = '0;
    for (int k = 0; k < Depth; k++) begin
      perf_instr_ret_spec_cnt_o   = perf_instr_ret_spec_cnt_o + CntW'(cnt_slot[k]);
      perf_instr_ret_c_spec_cnt_o = perf_instr_ret_c_spec_cnt_o + CntW'(cnt_c_slot[k]);
    end
  end

  // Reorder slots by age (position 0 = head) so the selector can pick the youngest match.
  logic [Depth-1:0]       match_a, match_b, age_is_load;
  logic [Depth-1:0][31:0] age_wdata;

  for (genvar gi = 0; gi < Depth; gi++) begin : g_age
    logic [PtrW:0]   sum;
    logic [PtrW-1:0] idx;
    logic            writes_rf;

    assign sum = {1'b0, head_ptr_reg} + (PtrW + 1)'(gi);
    assign idx = (sum >= (PtrW + 1)'(Depth)) ? PtrW'(sum - (PtrW + 1)'(Depth)) : sum[PtrW-1:0];
    assign writes_rf = valid_reg[idx] &
                       (entry_reg[idx].we | (entry_reg[idx].instr_type == WB_INSTR_LOAD));
    assign match_a[gi] = writes_rf & (entry_reg[idx].waddr == rf_raddr_a_i) & (rf_raddr_a_i != 5'd0);
    assign match_b[gi] = writes_rf & (entry_reg[idx].waddr == rf_raddr_b_i) & (rf_raddr_b_i != 5'd0);
    assign age_is_load[gi] = entry_reg[idx].instr_type == WB_INSTR_LOAD;
    assign age_wdata[gi]   = entry_reg[idx].wdata;
  end

  ibex_wb_fwd_match #(.Depth(Depth)) u_fwd_a (
    .match   (match_a),
    .is_load (age_is_load),
    .wdata   (age_wdata),
    .valid   (fwd_a_valid_o),
    .data    (fwd_a_data_o),
    .stall   (fwd_a_stall_o)
  );

  ibex_wb_fwd_match #(.Depth(Depth)) u_fwd_b (
    .match   (match_b),
    .is_load (age_is_load),
    .wdata   (age_wdata),
    .valid   (fwd_b_valid_o),
    .data    (fwd_b_data_o),
    .stall   (fwd_b_stall_o)
  );

  a_rf_we_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(id_we & rf_we_lsu_i));
  a_lsu_resp_head: assert property (@(posedge clk_i) disable iff (!rst_ni)
    lsu_resp_valid_i |-> (head_valid & (head.instr_type != WB_INSTR_OTHER)));
  a_no_enq_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(en_wb_i & full & ~head_done));

endmodule

// File: tb/tb_ibex_wb_queue.sv
// Scoreboard bench for ibex_wb_queue: a queue-based reference model produces
// per-cycle and per-retire expectations, a negedge monitor compares them.
module tb_ibex_wb_queue;
  import ibex_pkg::*;

  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          en_wb, rf_we_id, rf_we_lsu, lsu_resp_valid, lsu_resp_err, c_id, cnt_id;
  logic [1:0]    itype;
  logic [31:0]   pc_id, rf_wdata_id, rf_wdata_lsu;
  logic [4:0]    rf_waddr_id, raddr_a, raddr_b;
  logic          ready, rf_we, oload, ostore, done, perf, perf_c;
  logic          fav, fas, fbv, fbs;
  logic [4:0]    rf_waddr;
  logic [31:0]   rf_wdata, pc_wb, fad, fbd;
  logic [CW-1:0] spec_cnt, spec_c_cnt, occ;

  ibex_wb_queue #(.Depth(DEPTH), .ResetAll(1'b0)) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_wb_i(en_wb), .instr_type_wb_i(itype),
    .pc_id_i(pc_id), .instr_is_compressed_id_i(c_id), .instr_perf_count_id_i(cnt_id),
    .rf_waddr_id_i(rf_waddr_id), .rf_wdata_id_i(rf_wdata_id), .rf_we_id_i(rf_we_id),
    .rf_wdata_lsu_i(rf_wdata_lsu), .rf_we_lsu_i(rf_we_lsu),
    .lsu_resp_valid_i(lsu_resp_valid), .lsu_resp_err_i(lsu_resp_err),
    .rf_raddr_a_i(raddr_a), .rf_raddr_b_i(raddr_b),
    .ready_wb_o(ready), .rf_waddr_wb_o(rf_waddr), .rf_wdata_wb_o(rf_wdata), .rf_we_wb_o(rf_we),
    .outstanding_load_wb_o(oload), .outstanding_store_wb_o(ostore), .pc_wb_o(pc_wb),
    .instr_done_wb_o(done), .perf_instr_ret_wb_o(perf),
    .perf_instr_ret_compressed_wb_o(perf_c), .perf_instr_ret_spec_cnt_o(spec_cnt),
    .perf_instr_ret_c_spec_cnt_o(spec_c_cnt),
    .fwd_a_valid_o(fav), .fwd_a_data_o(fad), .fwd_a_stall_o(fas),
    .fwd_b_valid_o(fbv), .fwd_b_data_o(fbd), .fwd_b_stall_o(fbs),
    .occupancy_o(occ)
  );

  typedef struct {
    wb_instr_type_e t;
    bit             we;
    bit [4:0]       waddr;
    bit [31:0]      wdata;
    bit [31:0]      pc;
    bit             c;
    bit             cnt;
  } ment_t;

  typedef struct {
    bit [4:0]  waddr;
    bit [31:0] wdata;
    bit        we;
    bit [31:0] pc;
    bit        perf;
    bit        perf_c;
  } ret_t;

  typedef struct {
    bit        ready, done, rf_we, ol, os;
    int        occ, sc, scc;
    bit        av, as, bv, bs;
    bit [31:0] ad, bd;
  } st_t;

  ment_t mq[$];
  ret_t  retq[$];
  st_t   stq[$];
  int    checks = 0;
  int    errors = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Youngest entry that will write the register, searching from the tail of the model queue.
  function automatic void fwd_model(input bit [4:0] ra, output bit v, output bit s,
                                    output bit [31:0] d);
    v = 0; s = 0; d = 0;
    if (ra != 0) begin
      for (int k = mq.size() - 1; k >= 0; k--) begin
        if ((mq[k].we || mq[k].t == WB_INSTR_LOAD) && mq[k].waddr == ra) begin
          if (mq[k].t == WB_INSTR_LOAD) s = 1;
          else begin v = 1; d = mq[k].wdata; end
          break;
        end
      end
    end
  endfunction

  task automatic step(input bit en, input wb_instr_type_e t, input bit [4:0] wa,
                      input bit [31:0] wd, input bit we, input bit resp, input bit err,
                      input bit [31:0] ld, input bit [4:0] ra, input bit [4:0] rb,
                      input bit c, input bit cnt);
    ment_t head, e;
    st_t   s;
    ret_t  r;
    bit    hv, hd, rdy, lsu_we, id_we;
    int    n;
    n = mq.size();
    hv = n > 0;
    head = '{t: WB_INSTR_OTHER, we: 0, waddr: 0, wdata: 0, pc: 0, c: 0, cnt: 0};
    if (hv) head = mq[0];
    if (!hv || head.t == WB_INSTR_OTHER) resp = 0;
    hd     = hv && (head.t == WB_INSTR_OTHER || resp);
    rdy    = (n < DEPTH) || hd;
    if (!rdy) en = 0;
    if (t != WB_INSTR_OTHER) we = 0;
    lsu_we = resp && head.t == WB_INSTR_LOAD && !err;
    id_we  = hd && head.t == WB_INSTR_OTHER && head.we;

    s.ready = rdy; s.done = hd; s.rf_we = id_we || lsu_we; s.occ = n;
    s.ol = 0; s.os = 0; s.sc = 0; s.scc = 0;
    foreach (mq[k]) begin
      if (mq[k].t == WB_INSTR_LOAD)  s.ol = 1;
      if (mq[k].t == WB_INSTR_STORE) s.os = 1;
      if (mq[k].cnt) begin s.sc++; if (mq[k].c) s.scc++; end
    end
    fwd_model(ra, s.av, s.as, s.ad);
    fwd_model(rb, s.bv, s.bs, s.bd);
    stq.push_back(s);
    if (hd) begin
      r.waddr  = head.waddr;
      r.we     = id_we || lsu_we;
      r.wdata  = id_we ? head.wdata : (lsu_we ? ld : 32'h0);
      r.pc     = head.pc;
      r.perf   = head.cnt && !(resp && err);
      r.perf_c = r.perf && head.c;
      retq.push_back(r);
    end

    e = '{t: t, we: we, waddr: wa, wdata: wd, pc: $urandom & 32'hFFFF_FFFE, c: c, cnt: cnt};
    en_wb = en; itype = t; rf_waddr_id = wa; rf_wdata_id = wd; rf_we_id = we;
    pc_id = e.pc; c_id = c; cnt_id = cnt;
    lsu_resp_valid = resp; lsu_resp_err = resp & err;
    rf_we_lsu = lsu_we; rf_wdata_lsu = ld;
    raddr_a = ra; raddr_b = rb;

    @(posedge clk);
    if (hd) void'(mq.pop_front());
    if (en) mq.push_back(e);
    #1;
  endtask

  task automatic idle(input bit resp, input bit [31:0] ld, input bit [4:0] ra, input bit [4:0] rb);
    step(0, WB_INSTR_OTHER, 0, 0, 0, resp, 0, ld, ra, rb, 0, 0);
  endtask

  initial begin : monitor
    st_t  s;
    ret_t r;
    forever begin
      @(negedge clk);
      if (stq.size() > 0) begin
        s = stq.pop_front();
        chk("ready", 32'(ready), 32'(s.ready));
        chk("done", 32'(done), 32'(s.done));
        chk("rf_we", 32'(rf_we), 32'(s.rf_we));
        chk("occupancy", 32'(occ), 32'(s.occ));
        chk("out_load", 32'(oload), 32'(s.ol));
        chk("out_store", 32'(ostore), 32'(s.os));
        chk("spec_cnt", 32'(spec_cnt), 32'(s.sc));
        chk("spec_c_cnt", 32'(spec_c_cnt), 32'(s.scc));
        chk("fwd_a_valid", 32'(fav), 32'(s.av));
        chk("fwd_a_stall", 32'(fas), 32'(s.as));
        chk("fwd_a_data", fad, s.ad);
        chk("fwd_b_valid", 32'(fbv), 32'(s.bv));
        chk("fwd_b_stall", 32'(fbs), 32'(s.bs));
        chk("fwd_b_data", fbd, s.bd);
      end
      if (done) begin
        if (retq.size() == 0) chk("retire_expected", 32'(done), 32'h0);
        else begin
          r = retq.pop_front();
          chk("ret_waddr", 32'(rf_waddr), 32'(r.waddr));
          chk("ret_wdata", rf_wdata, r.wdata);
          chk("ret_we", 32'(rf_we), 32'(r.we));
          chk("ret_pc", pc_wb, r.pc);
          chk("ret_perf", 32'(perf), 32'(r.perf));
          chk("ret_perf_c", 32'(perf_c), 32'(r.perf_c));
          $display("retire waddr=%0d wdata=0x%08h we=%0b pc=0x%08h perf=%0b",
                   rf_waddr, rf_wdata, rf_we, pc_wb, perf);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    en_wb = 0; itype = 2'd2; pc_id = 0; c_id = 0; cnt_id = 0; rf_waddr_id = 0;
    rf_wdata_id = 0; rf_we_id = 0; rf_wdata_lsu = 0; rf_we_lsu = 0;
    lsu_resp_valid = 0; lsu_resp_err = 0; raddr_a = 0; raddr_b = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(ready), 32'h1);
    chk("rst_occupancy", 32'(occ), 32'h0);
    chk("rst_rf_we", 32'(rf_we), 32'h0);
    chk("rst_waddr", 32'(rf_waddr), 32'h0);
    chk("rst_pc", pc_wb, 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_spec_cnt", 32'(spec_cnt), 32'h0);
    rst_n = 1;
    @(posedge clk); #1;

    // ADD x5 = 0x11 retires one cycle after enqueue
    step(1, WB_INSTR_OTHER, 5, 32'h11, 1, 0, 0, 0, 0, 0, 0, 1);
    idle(0, 0, 5, 0);
    // Two loads fill the queue, then retire in order
    step(1, WB_INSTR_LOAD, 6, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    step(1, WB_INSTR_LOAD, 8, 0, 0, 0, 0, 0, 6, 8, 0, 1);
    idle(0, 0, 6, 8);
    idle(1, 32'hA, 0, 0);
    idle(1, 32'hB, 0, 0);
    // Full queue: retire and enqueue in the same cycle, pointers wrap
    step(1, WB_INSTR_LOAD, 9, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(1, WB_INSTR_LOAD, 10, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(1, WB_INSTR_OTHER, 11, 32'h55, 1, 1, 0, 32'hC, 0, 0, 0, 1);
    idle(1, 32'hD, 11, 10);
    idle(0, 0, 0, 0);
    // Youngest OTHER forwards
    step(1, WB_INSTR_OTHER, 3, 32'h1, 1, 0, 0, 0, 0, 0, 0, 0);
    step(1, WB_INSTR_OTHER, 3, 32'h2, 1, 0, 0, 0, 3, 0, 0, 0);
    idle(0, 0, 3, 0);
    // Younger LOAD shadows older OTHER: stall
    step(1, WB_INSTR_OTHER, 7, 32'h77, 1, 0, 0, 0, 0, 0, 0, 0);
    step(1, WB_INSTR_LOAD, 7, 0, 0, 0, 0, 0, 7, 7, 0, 0);
    idle(0, 0, 7, 7);
    idle(1, 32'h99, 7, 0);
    // Load with bus error still retires but does not count
    step(1, WB_INSTR_LOAD, 12, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    step(0, WB_INSTR_OTHER, 0, 0, 0, 1, 1, 32'hDEAD, 12, 0, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0,
           wb_instr_type_e'(2'($urandom_range(0, 2))),
           5'($urandom_range(0, 7)), $urandom, 1'($urandom),
           $urandom_range(0, 2) != 0, $urandom_range(0, 7) == 0, $urandom,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           1'($urandom), 1'($urandom));
    end
    for (int i = 0; i < 20 && mq.size() > 0; i++) idle(1, $urandom, 0, 0);
    chk("drained", 32'(mq.size()), 32'h0);

    // Asynchronous reset with entries in flight
    step(1, WB_INSTR_LOAD, 13, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(1, WB_INSTR_STORE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    rst_n = 0;
    mq.delete();
    en_wb = 0; lsu_resp_valid = 0; rf_we_lsu = 0;
    @(posedge clk); #1;
    chk("midrst_occupancy", 32'(occ), 32'h0);
    chk("midrst_ready", 32'(ready), 32'h1);
    chk("midrst_out_load", 32'(oload), 32'h0);
    rst_n = 1;
    @(posedge clk); #1;
    step(1, WB_INSTR_OTHER, 14, 32'h1234, 1, 0, 0, 0, 14, 0, 0, 1);
    idle(0, 0, 0, 0);
    @(negedge clk); #1;
    chk("retq_empty", 32'(retq.size()), 32'h0);
    chk("stq_empty", 32'(stq.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
